// File: rtl/arf124b256e1r1w0cbbehcaa4acw_port_ctl.sv
// Port controller for the 124b x 256-entry 1R1W latch-array regfile.
// Round-robin write arbitration, read hazard stall, zero-init after reset.
module arf124b256e1r1w0cbbehcaa4acw_port_ctl #(
  parameter int DWIDTH = 124,
  parameter int DEPTH  = 256,
  parameter int AWIDTH = 8,
  parameter int NREQ   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          wr_valid,
  output logic [NREQ-1:0]          wr_ready,
  input  logic [NREQ*AWIDTH-1:0]   wr_adr,
  input  logic [NREQ*DWIDTH-1:0]   wr_data,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [AWIDTH-1:0]        rd_adr,
  output logic                     arf_wren,
  output logic [AWIDTH-1:0]        arf_wradr,
  output logic [DWIDTH-1:0]        arf_wrdata,
  output logic                     arf_rden,
  output logic [AWIDTH-1:0]        arf_rdadr,
  output logic                     init_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic                wren_q, wren_d;
  logic [AWIDTH-1:0]   wradr_q, wradr_d;
  logic [DWIDTH-1:0]   wrdata_q, wrdata_d;
  logic                rden_q, rden_d;
  logic [AWIDTH-1:0]   rdadr_q, rdadr_d;
  logic                done_q, done_d;

  logic                run;
  logic                found;
  logic [PW-1:0]       gidx;
  logic [AWIDTH-1:0]   gadr;
  logic [DWIDTH-1:0]   gdata;
  logic                hazard;
  logic                rd_acc;

  assign run = (state_q == S_RUN);

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin : arb
    logic [PW-1:0] jj;
    found = 1'b0;
    gidx  = '0;
    jj    = '0;
    for (int k = 0; k < NREQ; k++) begin
      jj = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && wr_valid[jj]) begin
        found = 1'b1;
        gidx  = jj;
      end
    end
  end

  assign gadr  = wr_adr[int'(gidx)*AWIDTH +: AWIDTH];
  assign gdata = wr_data[int'(gidx)*DWIDTH +: DWIDTH];

  // One-hot grant, only while running.
  always_comb begin
    wr_ready = '0;
    if (run && found) wr_ready[gidx] = 1'b1;
  end

  // A read must not see a write still settling in the array.
  always_comb begin
    hazard = (wren_q && (wradr_q == rd_adr)) ||
             (run && found && (gadr == rd_adr));
    rd_ready = run && !hazard;
    rd_acc   = rd_valid && rd_ready;
  end

  // Next-state for the FSM, pointer and flopped array-side outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    wren_d   = 1'b0;
    wradr_d  = wradr_q;
    wrdata_d = wrdata_q;
    rden_d   = 1'b0;
    rdadr_d  = rdadr_q;
    done_d   = done_q;
    unique case (state_q)
      S_INIT: begin
        wren_d   = 1'b1;
        wradr_d  = cnt_q;
        wrdata_d = '0;
        cnt_d    = cnt_q + AWIDTH'(1);
        if (cnt_q == AWIDTH'(DEPTH - 1)) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (found) begin
          wren_d   = 1'b1;
          wradr_d  = gadr;
          wrdata_d = gdata;
          ptr_d    = PW'((int'(gidx) + 1) % NREQ);
        end
        if (rd_acc) begin
          rden_d  = 1'b1;
          rdadr_d = rd_adr;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      ptr_q    <= '0;
      wren_q   <= 1'b0;
      wradr_q  <= '0;
      wrdata_q <= '0;
      rden_q   <= 1'b0;
      rdadr_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      wren_q   <= wren_d;
      wradr_q  <= wradr_d;
      wrdata_q <= wrdata_d;
      rden_q   <= rden_d;
      rdadr_q  <= rdadr_d;
      done_q   <= done_d;
    end
  end

  assign arf_wren   = wren_q;
  assign arf_wradr  = wradr_q;
  assign arf_wrdata = wrdata_q;
  assign arf_rden   = rden_q;
  assign arf_rdadr  = rdadr_q;
  assign init_done  = done_q;

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(wr_ready));

  a_no_rd_on_wr: assert property (
    @(posedge clk) disable iff (rst)
    !(rden_q && wren_q && (rdadr_q == wradr_q)));

  a_done_in_run: assert property (
    @(posedge clk) disable iff (rst) run |-> done_q);

endmodule

// File: doc/arf124b256e1r1w0cbbehcaa4acw_port_ctl.md
Name: arf124b256e1r1w0cbbehcaa4acw_port_ctl

Overview:
- Port controller for the 124b x 256-entry 1R1W latch-array register file.
- Shares the single write port between NREQ requesters using round-robin arbitration.
- Sequences reads and stalls any read that would observe a write still settling in the phase-B latches.
- Zero-initialises the whole array after reset.
- Sits between the requester pipelines and the array wrapper; all array-side outputs are flopped.

Parameters:
- DWIDTH, 124: data width per entry.
- DEPTH, 256: number of entries; must satisfy DEPTH <= 2**AWIDTH.
- AWIDTH, 8: address width.
- NREQ, 2: number of write requesters (2..4).

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- wr_valid  in  NREQ  per-requester write request.
- wr_ready  out  NREQ  per-requester grant; a transfer occurs when valid&ready.
- wr_adr  in  NREQ*AWIDTH  packed write addresses; requester i occupies slice [i*AWIDTH +: AWIDTH].
- wr_data  in  NREQ*DWIDTH  packed write data; requester i occupies slice [i*DWIDTH +: DWIDTH].
- rd_valid  in  1  read request.
- rd_ready  out  1  read accept.
- rd_adr  in  AWIDTH  read address.
- arf_wren  out  1  array write enable (flopped).
- arf_wradr  out  AWIDTH  array write address (flopped).
- arf_wrdata  out  DWIDTH  array write data (flopped).
- arf_rden  out  1  array read enable (flopped).
- arf_rdadr  out  AWIDTH  array read address (flopped).
- init_done  out  1  high once zero-init is complete.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (cycle after rst sampled high): every output is 0; state=INIT; init counter=0; round-robin pointer gives priority to requester 0.
- FSM state INIT:
  - Each cycle drive arf_wren=1, arf_wradr=cnt, arf_wrdata=0; then cnt++.
  - After the write with cnt=DEPTH-1 is issued, go to RUN. init_done rises in the same cycle the state becomes RUN.
  - wr_ready=0 and rd_ready=0 throughout INIT.
  - Init takes exactly DEPTH cycles of writes.
- FSM state RUN: stays in RUN until rst.
- Write arbitration (RUN):
  - wr_ready is combinational from wr_valid and the pointer; at most one bit is set per cycle.
  - Grant goes to the first valid requester at or after the pointer, wrapping modulo NREQ.
  - After a grant, the pointer becomes granted+1 mod NREQ. The pointer is unchanged on idle cycles.
  - Requester i is never granted while wr_valid[i]=0.
- Write latency: a grant in cycle N produces arf_wren=1 with the granted address/data in cycle N+1.
  - With no grant, arf_wren=0 and arf_wradr/arf_wrdata hold their previous values (no toggling).
- Read path:
  - rd_ready = RUN & ~hazard.
  - hazard = (arf_wren & arf_wradr==rd_adr) | (write granted this cycle & granted address==rd_adr).
  - An accepted read in cycle N produces arf_rden=1, arf_rdadr=rd_adr in cycle N+1.
  - With no read, arf_rden=0 and arf_rdadr holds.
  - Read data returns from the array; the controller does not carry read data.
- Stall rules:
  - A stalled read keeps rd_valid and rd_adr stable (requester obligation).
  - A stall lasts at most 2 cycles per conflicting write.
  - Writes are never stalled by reads.
- Simultaneous events:
  - A read and a write to different addresses in the same cycle are both accepted.
  - A read and a write to the same address: the write wins, the read is stalled.
- Address range: addresses >= DEPTH are a requester error; the controller passes them through unchecked.
- Reset mid-operation: any in-flight flopped write/read is dropped (enables cleared); FSM restarts INIT from entry 0; init_done falls.
- Assertions:
  - wr_ready is onehot0.
  - No arf_rden while arf_wren is set to the same address as the previous cycle's grant.
  - init_done is stable high in RUN.

Test Plan:
- Init sequence: assert rst 3 cycles, release -> arf_wren=1 for exactly 256 consecutive cycles with arf_wradr 0..255 and arf_wrdata=0; init_done=1 in the cycle after the address-255 write; wr_ready=rd_ready=0 throughout.
- Round-robin fairness: after init, hold wr_valid=2'b11 for 6 cycles -> grants 0,1,0,1,0,1; arf_wradr follows each requester's address with 1-cycle latency.
- Single requester: wr_valid=2'b10 only -> requester 1 is granted every cycle, and then requester 0 has priority once both are valid.
- Hazard: grant a write to address 0x2A in cycle N with rd_adr=0x2A valid -> rd_ready=0 in N and N+1, rd_ready=1 in N+2, arf_rden=1 with arf_rdadr=0x2A in N+3. A read to 0x2B in cycle N is accepted immediately.
- Reset mid-RUN: issue writes, assert rst for 1 cycle -> next cycle arf_wren=0, arf_rden=0, init_done=0; init restarts at address 0 and pointer priority returns to requester 0.
